// File: rtl/telemetria_n_canais.sv
// telemetria_n_canais
// Captures a snapshot of N_CH BCD distance measurements and streams them as
// ASCII through an external 7E1 serial transmitter, one character at a time.
// Frame: for each enabled channel, DIGITS digits (MSD first) plus SEP, then
// one TERM. Non-BCD nibbles are sent as '?'. A missing tx_pronto for
// TIMEOUT cycles aborts the frame and raises the sticky erro flag.
//
// Handshake: tx_partida is a one-cycle pulse; tx_dados is already stable when
// it rises and stays stable until the next character is loaded. The
// transmitter answers with a one-cycle tx_pronto when the character is done;
// tx_pronto is only listened to while waiting for it (ESPERA).
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   iniciar    start-frame request (only honoured while idle)
//   medidas    packed BCD values, channel c at [c*DIGITS*4 +: DIGITS*4]
//   habilita   per-channel enable mask
//   tx_pronto  end-of-character pulse from the transmitter
//   tx_partida start-of-character pulse to the transmitter
//   tx_dados   ASCII character to transmit
//   ocupado    high whenever not idle
//   fim        one-cycle pulse on normal frame completion
//   erro       sticky handshake-timeout flag
//   db_estado  current state encoding
module telemetria_n_canais #(
    parameter int         N_CH    = 3,
    parameter int         DIGITS  = 3,
    parameter logic [6:0] SEP     = 7'h23,
    parameter logic [6:0] TERM    = 7'h0A,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic [N_CH*DIGITS*4-1:0] medidas,
    input  logic [N_CH-1:0]          habilita,
    input  logic                     tx_pronto,
    output logic                     tx_partida,
    output logic [6:0]               tx_dados,
    output logic                     ocupado,
    output logic                     fim,
    output logic                     erro,
    output logic [3:0]               db_estado
);

    localparam int MW = N_CH * DIGITS * 4;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(MW);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CAPTURA = 4'd1,
        CARREGA = 4'd2,
        ENVIA   = 4'd3,
        ESPERA  = 4'd4,
        PROXIMO = 4'd5,
        FIM     = 4'd6,
        ABORTA  = 4'd7
    } estado_t;

    estado_t         estado, prox;
    logic [MW-1:0]   snap_med;
    logic [N_CH-1:0] snap_hab;
    logic [CW-1:0]   ch_idx;
    logic [DW-1:0]   dig_idx;
    logic            em_sep;
    logic            em_term;
    logic [TW-1:0]   tempo;

    logic [CW-1:0]   first_ch;
    logic [CW-1:0]   next_ch;
    logic            has_next;
    logic [BW-1:0]   bit_base;
    logic [3:0]      bcd;
    logic [6:0]      char_atual;
    logic            estouro;

    // Lowest enabled channel of the live mask (used at capture time).
    // Scanning downward leaves the lowest match in the result.
    always_comb begin
        first_ch = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (habilita[c]) first_ch = CW'(c);
        end
    end

    // Next enabled channel above the current one in the snapshot mask. When
    // none exists the frame moves on to the terminator, so ch_idx never wraps.
    always_comb begin
        has_next = 1'b0;
        next_ch  = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (snap_hab[c] && (c > int'(ch_idx))) begin
                has_next = 1'b1;
                next_ch  = CW'(c);
            end
        end
    end

    // Digit index 0 is the most significant nibble of the channel.
    always_comb begin
        bit_base = BW'((int'(ch_idx) * DIGITS + (DIGITS - 1 - int'(dig_idx))) * 4);
        bcd      = snap_med[bit_base +: 4];
    end

    always_comb begin
        if (em_term)          char_atual = TERM;
        else if (em_sep)      char_atual = SEP;
        else if (bcd <= 4'd9) char_atual = {3'b011, bcd};
        else                  char_atual = 7'h3F;
    end

    assign estouro = (tempo == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (iniciar) prox = CAPTURA;
            CAPTURA: prox = CARREGA;
            CARREGA: prox = ENVIA;
            ENVIA:   prox = ESPERA;
            ESPERA: begin
                if (tx_pronto)    prox = PROXIMO;
                else if (estouro) prox = ABORTA;
            end
            PROXIMO: prox = em_term ? FIM : CARREGA;
            FIM:     prox = OCIOSO;
            ABORTA:  prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    assign ocupado   = (estado != OCIOSO);
    assign fim       = (estado == FIM);
    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_partida <= 1'b0;
            tx_dados   <= '0;
            erro       <= 1'b0;
            snap_med   <= '0;
            snap_hab   <= '0;
            ch_idx     <= '0;
            dig_idx    <= '0;
            em_sep     <= 1'b0;
            em_term    <= 1'b0;
            tempo      <= '0;
        end else begin
            // Registered so the pulse appears in the first ESPERA cycle.
            tx_partida <= (estado == ENVIA);
            case (estado)
                OCIOSO: if (iniciar) erro <= 1'b0;
                CAPTURA: begin
                    snap_med <= medidas;
                    snap_hab <= habilita;
                    ch_idx   <= first_ch;
                    dig_idx  <= '0;
                    em_sep   <= 1'b0;
                    em_term  <= (habilita == '0);
                end
                CARREGA: tx_dados <= char_atual;
                ENVIA:   tempo <= '0;
                ESPERA: begin
                    if (!tx_pronto) begin
                        if (estouro) erro  <= 1'b1;
                        else         tempo <= tempo + 1'b1;
                    end
                end
                PROXIMO: begin
                    if (!em_term) begin
                        if (em_sep) begin
                            if (has_next) begin
                                ch_idx  <= next_ch;
                                dig_idx <= '0;
                                em_sep  <= 1'b0;
                            end else begin
                                em_term <= 1'b1;
                            end
                        end else if (dig_idx == DW'(DIGITS - 1)) begin
                            em_sep <= 1'b1;
                        end else begin
                            dig_idx <= dig_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetria_n_canais.sv
module tb_telemetria_n_canais;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [35:0] medidas;
    logic [2:0]  habilita;
    logic        tx_pronto;
    logic        tx_partida;
    logic [6:0]  tx_dados;
    logic        ocupado;
    logic        fim;
    logic        erro;
    logic [3:0]  db_estado;

    logic [6:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         fim_count = 0;
    bit         responder_on = 1'b1;

    telemetria_n_canais #(
        .N_CH(3), .DIGITS(3), .SEP(7'h23), .TERM(7'h0A), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .medidas(medidas),
        .habilita(habilita), .tx_pronto(tx_pronto), .tx_partida(tx_partida),
        .tx_dados(tx_dados), .ocupado(ocupado), .fim(fim), .erro(erro),
        .db_estado(db_estado)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required frame completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Push n expected characters, given MSB-first one per byte.
    task automatic expect_chars(input int n, input logic [103:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 7]);
    endtask

    // Transmitter model: answer every tx_partida with tx_pronto sampled
    // five edges after the edge that raised tx_partida.
    initial begin
        tx_pronto = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_partida && responder_on) begin
                repeat (4) @(negedge clock);
                tx_pronto = 1'b1;
                @(negedge clock);
                tx_pronto = 1'b0;
            end
        end
    end

    // Monitor: every tx_partida must match the next expected character.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clock);
            if (tx_partida) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_partida: got tx_dados=%0h, required no character", tx_dados);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_dados", 32'(tx_dados), 32'(e));
                end
            end
            if (fim) fim_count++;
        end
    end

    // Driver: run one frame; expected characters must already be queued.
    task automatic run_frame(input logic [35:0] med, input logic [2:0] hab,
                             input bit scramble, input bit poke_busy);
        int f0;
        int lat;
        int n;
        @(negedge clock);
        medidas  = med;
        habilita = hab;
        iniciar  = 1'b1;
        f0       = fim_count;
        @(negedge clock);
        iniciar = 1'b0;
        check("erro_cleared_on_start", 32'(erro), 32'd0);
        check("ocupado_in_frame", 32'(ocupado), 32'd1);
        @(negedge clock);
        lat = 2;
        if (scramble) begin
            medidas  = 36'h5A5A5A5A5;
            habilita = ~hab;
        end
        while (!tx_partida && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("first_partida_latency", 32'(lat), 32'd4);
        if (poke_busy) begin
            iniciar = 1'b1;
            @(negedge clock);
            iniciar = 1'b0;
        end
        n = 0;
        while (!fim && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no fim in 400 cycles, required fim");
        end
        repeat (30) @(negedge clock);
        check("fim_pulses", 32'(fim_count - f0), 32'd1);
        check("erro_after_frame", 32'(erro), 32'd0);
        check("chars_left", 32'(exp_q.size()), 32'd0);
        check("ocupado_idle", 32'(ocupado), 32'd0);
    endtask

    initial begin
        int n;
        int f0;
        int np;
        reset    = 1'b1;
        iniciar  = 1'b0;
        medidas  = '0;
        habilita = '0;
        repeat (3) @(negedge clock);
        check("rst_partida", 32'(tx_partida), 32'd0);
        check("rst_dados", 32'(tx_dados), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_fim", 32'(fim), 32'd0);
        check("rst_erro", 32'(erro), 32'd0);
        check("rst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Full frame, all channels, inputs scrambled after capture.
        expect_chars(13, 104'h31_32_33_23_30_34_35_23_39_39_39_23_0A);
        run_frame(36'h999045123, 3'b111, 1'b1, 1'b0);

        // Only channel 1, with an ignored iniciar while busy.
        expect_chars(5, 104'h30_34_35_23_0A);
        run_frame(36'h999045123, 3'b010, 1'b0, 1'b1);

        // Empty mask: terminator only.
        expect_chars(1, 104'h0A);
        run_frame(36'h999045123, 3'b000, 1'b0, 1'b0);

        // Non-BCD digit flagged as '?', inputs scrambled after capture.
        expect_chars(5, 104'h31_3F_33_23_0A);
        run_frame(36'h0000001A3, 3'b001, 1'b1, 1'b0);

        // Handshake timeout.
        responder_on = 1'b0;
        expect_chars(1, 104'h31);
        f0 = fim_count;
        @(negedge clock);
        medidas  = 36'h000000123;
        habilita = 3'b001;
        iniciar  = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        n = 0;
        while (!tx_partida && n < 20) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (!erro && n < 30) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd8);
        check("timeout_estado", 32'(db_estado), 32'd7);
        @(negedge clock);
        check("timeout_ocupado", 32'(ocupado), 32'd0);
        repeat (10) @(negedge clock);
        check("timeout_erro_sticky", 32'(erro), 32'd1);
        check("timeout_no_fim", 32'(fim_count - f0), 32'd0);
        check("timeout_queue", 32'(exp_q.size()), 32'd0);
        responder_on = 1'b1;

        // New start clears erro and sends a full frame.
        expect_chars(13, 104'h31_32_33_23_30_34_35_23_39_39_39_23_0A);
        run_frame(36'h999045123, 3'b111, 1'b0, 1'b0);

        // Reset during the third ESPERA.
        expect_chars(3, 104'h31_32_33);
        f0 = fim_count;
        @(negedge clock);
        medidas  = 36'h999045123;
        habilita = 3'b111;
        iniciar  = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        np = 0;
        n  = 0;
        while (np < 3 && n < 200) begin
            @(negedge clock);
            n++;
            if (tx_partida) np++;
        end
        check("third_partida_seen", 32'(np), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_partida", 32'(tx_partida), 32'd0);
        check("midrst_dados", 32'(tx_dados), 32'd0);
        check("midrst_ocupado", 32'(ocupado), 32'd0);
        check("midrst_fim", 32'(fim), 32'd0);
        check("midrst_erro", 32'(erro), 32'd0);
        check("midrst_estado", 32'(db_estado), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("midrst_no_fim", 32'(fim_count - f0), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        check("midrst_idle", 32'(ocupado), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
